ft_channel_select: RTL and testbench
====================================

// Module: ft_channel_select
// PURPOSE
//  Parametrised, registered N-way W-bit channel selector with fault-driven failover.
//  Sits after the redundant RCA copies: forwards the active copy's sum, watches per-copy
//  fault flags, and switches to the next healthy copy once a fault persists for HOLD cycles.
//  Software/test override pins any channel by force.
// PARAMETERS
//  NCH   4  number of redundant input channels (>=2); SW = $clog2(NCH) localparam
//  W     8  data width per channel
//  HOLD  3  consecutive faulty cycles on the active channel before failover (>=1)
// PORTS
//  clk         in   1      clock, rising edge
//  rst_n       in   1      asynchronous active-low reset
//  in_data     in   NCH*W  channel i at [i*W +: W]
//  in_fault    in   NCH    per-channel fault flag, 1 = faulty
//  in_valid    in   1      in_data qualifier
//  force_en    in   1      manual override enable
//  force_sel   in   SW     channel to pin when force_en=1
//  out_data    out  W      registered selected data
//  out_valid   out  1      registered qualifier
//  active_sel  out  SW     currently selected channel
//  failover    out  1      1-cycle pulse on automatic switch
//  all_fail    out  1      no healthy channel available
// BEHAVIOUR
//  - Reset (async, rst_n=0): active_sel=0, out_data=0, out_valid=0, failover=0, all_fail=0,
//    state=ACTIVE, debounce count=0. Release takes effect on the next rising edge.
//  - Datapath, 1-cycle latency: out_data <= in_data[active_sel] when in_valid=1, else holds.
//    out_valid <= in_valid & ~in_fault[active_sel] & (state!=DEAD). Uses pre-edge active_sel.
//  - FSM states: ACTIVE, DEBOUNCE, SWITCH, DEAD.
//    ACTIVE: fault on active sampled -> count=1; to SWITCH if HOLD==1, else DEBOUNCE.
//    DEBOUNCE: fault persists -> count++; count reaching HOLD -> SWITCH. Fault clears -> ACTIVE, count=0.
//    SWITCH (one cycle, no re-check): search channels active_sel+1, +2, ... with wrap modulo NCH,
//      excluding active_sel. First with in_fault=0 becomes active_sel, failover=1 for one cycle,
//      -> ACTIVE. None found -> all_fail=1, active_sel unchanged, -> DEAD.
//    DEAD: any channel healthy -> same wrap search from active_sel+1 including active_sel last;
//      winner loaded, all_fail=0, failover=1, -> ACTIVE.
//  - Timing: active_sel changes on the (HOLD+1)th edge counting the first fault-sampling edge as 1.
//  - Force: force_en=1 with force_sel<NCH -> active_sel<=force_sel next edge, state=ACTIVE,
//    count=0, all_fail=0, no failover pulse; automatic FSM frozen while force_en=1, even if forced
//    channel faulty (out_valid still masks it). force_sel>=NCH: ignored, FSM frozen.
//  - force_en has priority over any simultaneous FSM transition.
//  - Failover pulse never lasts more than one cycle; back-to-back switches need a new HOLD period.
// CONFIGURATION
//  FT_SELECT_STICKY_EN defined: channel left by an automatic failover is set in a sticky
//    exclusion mask, treated as faulty by all later searches until reset; force may still select
//    it and clears its mask bit. All channels masked/faulty -> DEAD.
//  Undefined: searches use only the current in_fault; no mask state exists.
// TESTING (NCH=4, W=8, HOLD=3 unless noted)
//  1 Reset mid-operation with out_valid=1 -> all outputs 0 asynchronously, active_sel=0.
//  2 in_valid=1, ch0=0x3C, no faults -> out_data=0x3C, out_valid=1 one edge later, failover=0.
//  3 in_fault[0] high 2 edges then low -> no switch, active_sel=0; high 3 edges -> active_sel=1
//    on 4th edge, failover 1-cycle pulse, out_valid=0 while ch0 faulty.
//  4 active=3, in_fault=4'b1011 for 3 edges -> wrap search picks ch2; in_fault=4'b1111 -> all_fail=1,
//    out_valid=0; then clear in_fault[1] -> active_sel=1, all_fail=0, failover pulse.
//  5 force_en=1, force_sel=2 while in DEBOUNCE -> active_sel=2 next edge, no failover; force_sel=5
//    -> active_sel unchanged.
//  6 STICKY_EN: fail over 0->1, clear fault[0], fault ch1 HOLD cycles -> selects ch2, never ch0.

Source files
------------

// File: rtl/ft_channel_select.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ft_channel_select : registered N-way channel selector, fault failover.   |
// | Option macro FT_SELECT_STICKY_EN : sticky exclusion of abandoned copies. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module ft_channel_select #(
  parameter int NCH  = 4,
  parameter int W    = 8,
  parameter int HOLD = 3,
  localparam int SW  = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH*W-1:0] in_data,
  input  logic [NCH-1:0]   in_fault,
  input  logic             in_valid,
  input  logic             force_en,
  input  logic [SW-1:0]    force_sel,
  output logic [W-1:0]     out_data,
  output logic             out_valid,
  output logic [SW-1:0]    active_sel,
  output logic             failover,
  output logic             all_fail
);

  localparam int            CW     = $clog2(HOLD + 1);
  localparam logic [CW-1:0] HOLD_C = CW'(HOLD);
  localparam logic [SW:0]   NCH_C  = (SW + 1)'(NCH);

  typedef enum logic [1:0] {
    ST_ACTIVE   = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_SWITCH   = 2'd2,
    ST_DEAD     = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [NCH-1:0] healthy;
  logic          act_fault;
  logic          force_ok;
  logic          sw_found;
  logic          dead_found;
  logic [SW-1:0] sw_next;
  logic [SW-1:0] dead_next;
  logic [SW-1:0] ch;

`ifdef FT_SELECT_STICKY_EN
  logic [NCH-1:0] excl;
  assign healthy = ~in_fault & ~excl;
`else
  assign healthy = ~in_fault;
`endif

  assign act_fault = in_fault[active_sel];
  assign force_ok  = ({1'b0, force_sel} < NCH_C);

  // Walk from farthest to nearest so the nearest healthy channel wins; k==NCH is the
  // active channel itself, which only the DEAD recovery search may pick.
  always_comb begin
    sw_found   = 1'b0;
    dead_found = 1'b0;
    sw_next    = active_sel;
    dead_next  = active_sel;
    ch         = '0;
    for (int k = NCH; k >= 1; k--) begin
      ch = SW'((int'(active_sel) + k) % NCH);
      if (healthy[ch]) begin
        dead_found = 1'b1;
        dead_next  = ch;
        if (k != NCH) begin
          sw_found = 1'b1;
          sw_next  = ch;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_ACTIVE;
      count      <= '0;
      active_sel <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      failover   <= 1'b0;
      all_fail   <= 1'b0;
`ifdef FT_SELECT_STICKY_EN
      excl       <= '0;
`endif
    end else begin
      failover  <= 1'b0;
      if (in_valid) begin
        out_data <= in_data[active_sel*W +: W];
      end
      out_valid <= in_valid & ~act_fault & (state != ST_DEAD);

      if (force_en) begin
        // Out-of-range selections leave everything frozen.
        if (force_ok) begin
          active_sel <= force_sel;
          state      <= ST_ACTIVE;
          count      <= '0;
          all_fail   <= 1'b0;
`ifdef FT_SELECT_STICKY_EN
          excl[force_sel] <= 1'b0;
`endif
        end
      end else begin
        case (state)
          ST_ACTIVE: begin
            if (act_fault) begin
              count <= CW'(1);
              state <= (HOLD == 1) ? ST_SWITCH : ST_DEBOUNCE;
            end
          end
          ST_DEBOUNCE: begin
            if (act_fault) begin
              count <= count + CW'(1);
              if (count + CW'(1) == HOLD_C) begin
                state <= ST_SWITCH;
              end
            end else begin
              count <= '0;
              state <= ST_ACTIVE;
            end
          end
          ST_SWITCH: begin
            count <= '0;
            if (sw_found) begin
              active_sel <= sw_next;
              failover   <= 1'b1;
              state      <= ST_ACTIVE;
`ifdef FT_SELECT_STICKY_EN
              excl[active_sel] <= 1'b1;
`endif
            end else begin
              all_fail <= 1'b1;
              state    <= ST_DEAD;
            end
          end
          ST_DEAD: begin
            if (dead_found) begin
              active_sel <= dead_next;
              all_fail   <= 1'b0;
              failover   <= 1'b1;
              state      <= ST_ACTIVE;
`ifdef FT_SELECT_STICKY_EN
              if (dead_next != active_sel) begin
                excl[active_sel] <= 1'b1;
              end
`endif
            end
          end
          default: state <= ST_ACTIVE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ft_channel_select.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ft_channel_select : directed scoreboard bench for ft_channel_select.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_ft_channel_select;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_fault;
  logic        in_valid;
  logic        force_en;
  logic [1:0]  force_sel;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [1:0]  active_sel;
  logic        failover;
  logic        all_fail;

  // Five-channel instance: the only way to present force_sel >= NCH.
  logic [39:0] in_data5;
  logic [4:0]  in_fault5;
  logic        in_valid5;
  logic        force_en5;
  logic [2:0]  force_sel5;
  logic [7:0]  out_data5;
  logic        out_valid5;
  logic [2:0]  active_sel5;
  logic        failover5;
  logic        all_fail5;

  int         n_cmp  = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  ft_channel_select #(.NCH(4), .W(8), .HOLD(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_fault(in_fault),
    .in_valid(in_valid), .force_en(force_en), .force_sel(force_sel),
    .out_data(out_data), .out_valid(out_valid), .active_sel(active_sel),
    .failover(failover), .all_fail(all_fail)
  );

  ft_channel_select #(.NCH(5), .W(8), .HOLD(3)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data5), .in_fault(in_fault5),
    .in_valid(in_valid5), .force_en(force_en5), .force_sel(force_sel5),
    .out_data(out_data5), .out_valid(out_valid5), .active_sel(active_sel5),
    .failover(failover5), .all_fail(all_fail5)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [3:0] f, input logic v, input logic exp_ov,
                       input logic [7:0] exp_d);
    in_fault = f;
    in_valid = v;
    if (exp_ov) exp_q.push_back(exp_d);
    step();
  endtask

  // Monitor: every presented output word must match the oldest expectation.
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_out_valid: got data %0h, expected no output", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin
            n_fail++;
            $display("FAIL out_data: got %0h, expected %0h", out_data, e);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n      = 1'b0;
    in_data    = {8'h44, 8'h33, 8'h22, 8'h3C};
    in_fault   = 4'b0000;
    in_valid   = 1'b0;
    force_en   = 1'b0;
    force_sel  = 2'd0;
    in_data5   = '0;
    in_fault5  = '0;
    in_valid5  = 1'b0;
    force_en5  = 1'b0;
    force_sel5 = 3'd0;
    step();
    step();
    chk("rst_active_sel", active_sel, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_failover", failover, 0);
    chk("rst_all_fail", all_fail, 0);
    rst_n = 1'b1;

    // Plain forwarding of channel 0.
    apply(4'b0000, 1'b1, 1'b1, 8'h3C);
    chk("fwd_out_valid", out_valid, 1);
    chk("fwd_failover", failover, 0);

    // Asynchronous reset while out_valid is high.
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_out_data", out_data, 0);
    chk("async_rst_active_sel", active_sel, 0);
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    // Short fault burst: no switch.
    apply(4'b0001, 1'b1, 1'b0, 8'h00);
    apply(4'b0001, 1'b1, 1'b0, 8'h00);
    apply(4'b0000, 1'b1, 1'b1, 8'h3C);
    chk("short_fault_active_sel", active_sel, 0);
    // Persistent fault: switch on the 4th edge.
    apply(4'b0001, 1'b1, 1'b0, 8'h00);
    apply(4'b0001, 1'b1, 1'b0, 8'h00);
    apply(4'b0001, 1'b1, 1'b0, 8'h00);
    chk("hold_active_sel_before", active_sel, 0);
    chk("faulty_out_valid", out_valid, 0);
    apply(4'b0001, 1'b1, 1'b0, 8'h00);
    chk("switch_active_sel", active_sel, 1);
    chk("switch_failover", failover, 1);
    apply(4'b0001, 1'b1, 1'b1, 8'h22);
    chk("failover_pulse_end", failover, 0);

    // Wrap-around search from channel 3.
    force_en  = 1'b1;
    force_sel = 2'd3;
    apply(4'b0000, 1'b0, 1'b0, 8'h00);
    chk("force3_active_sel", active_sel, 3);
    chk("force3_failover", failover, 0);
    force_en = 1'b0;
    apply(4'b1011, 1'b0, 1'b0, 8'h00);
    apply(4'b1011, 1'b0, 1'b0, 8'h00);
    apply(4'b1011, 1'b0, 1'b0, 8'h00);
    chk("wrap_before", active_sel, 3);
    apply(4'b1011, 1'b0, 1'b0, 8'h00);
    chk("wrap_active_sel", active_sel, 2);
    chk("wrap_failover", failover, 1);

    // Everything faulty: DEAD, then recover to channel 1.
    for (int i = 0; i < 4; i++) apply(4'b1111, 1'b0, 1'b0, 8'h00);
    chk("dead_all_fail", all_fail, 1);
    chk("dead_active_sel", active_sel, 2);
    chk("dead_failover", failover, 0);
    apply(4'b1111, 1'b1, 1'b0, 8'h00);
    chk("dead_out_valid", out_valid, 0);
    apply(4'b1101, 1'b0, 1'b0, 8'h00);
    chk("recover_active_sel", active_sel, 1);
    chk("recover_all_fail", all_fail, 0);
    chk("recover_failover", failover, 1);
    apply(4'b1101, 1'b1, 1'b1, 8'h22);

    // Force during DEBOUNCE, then frozen FSM with a faulty forced channel.
    apply(4'b0010, 1'b0, 1'b0, 8'h00);
    apply(4'b0010, 1'b0, 1'b0, 8'h00);
    force_en  = 1'b1;
    force_sel = 2'd2;
    apply(4'b0010, 1'b0, 1'b0, 8'h00);
    chk("force_deb_active_sel", active_sel, 2);
    chk("force_deb_failover", failover, 0);
    for (int i = 0; i < 5; i++) apply(4'b0100, 1'b1, 1'b0, 8'h00);
    chk("frozen_active_sel", active_sel, 2);
    chk("frozen_failover", failover, 0);
    chk("frozen_all_fail", all_fail, 0);
    chk("frozen_out_valid", out_valid, 0);
    force_en = 1'b0;
    apply(4'b0000, 1'b1, 1'b1, 8'h33);
    chk("release_active_sel", active_sel, 2);
    in_valid = 1'b0;

    // Out-of-range force on the five-channel instance.
    force_en5  = 1'b1;
    force_sel5 = 3'd3;
    step();
    chk("n5_force3", active_sel5, 3);
    force_sel5 = 3'd5;
    step();
    step();
    chk("n5_force5_ignored", active_sel5, 3);
    force_sel5 = 3'd7;
    step();
    chk("n5_force7_ignored", active_sel5, 3);
    chk("n5_all_fail", all_fail5, 0);
    force_en5 = 1'b0;

    // Sticky exclusion contrast: fail 0->1, then only ch0 is healthy.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) apply(4'b0001, 1'b0, 1'b0, 8'h00);
    chk("seq6_first_switch", active_sel, 1);
    for (int i = 0; i < 4; i++) apply(4'b1110, 1'b0, 1'b0, 8'h00);
`ifdef FT_SELECT_STICKY_EN
    chk("sticky_active_sel", active_sel, 1);
    chk("sticky_all_fail", all_fail, 1);
`else
    chk("nonsticky_active_sel", active_sel, 0);
    chk("nonsticky_failover", failover, 1);
`endif
    force_en  = 1'b1;
    force_sel = 2'd0;
    apply(4'b1110, 1'b0, 1'b0, 8'h00);
    chk("seq6_force0_active_sel", active_sel, 0);
    chk("seq6_force0_all_fail", all_fail, 0);
    force_en = 1'b0;

    step();
    step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
